mpu_host_sequencer: RTL
=======================

# mpu_host_sequencer

Host-side issuer for the matrix processing unit's instruction controller. Accepts 8-bit instructions over a valid/ready port and presents each one on `host_instruction` for exactly one cycle while the controller is idle. For LOAD it pre-buffers a 64-byte chunk and streams it to the controller at one byte per cycle. For UNLOAD it captures the 64 bytes the controller reads out and drains them to the host over a valid/ready stream.

## Interface
- `CHUNK_BYTES`, 64: bytes per LOAD/UNLOAD; fixed by the controller's 64-step sequence.
- `CAP_DELAY`, 1: cycles from a controller UNLOAD step to valid `unload_data`. Range 0–3.
- `TIMEOUT`, 255: maximum cycles to wait for `busy` low before flagging an error.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  host command present.
- `cmd_instr`  in  8  instruction as `{DD[7:6], AA[5:4], op[3:0]}`.
- `cmd_ready`  out  1  sequencer can accept a command.
- `in_valid`  in  1  LOAD fill byte present.
- `in_data`  in  8  LOAD fill byte.
- `in_ready`  out  1  fill byte accepted.
- `out_valid`  out  1  UNLOAD drain byte present.
- `out_data`  out  8  UNLOAD drain byte.
- `out_ready`  in  1  host takes drain byte.
- `busy`  in  1  controller busy; low only in the controller's IDLE.
- `unload_data`  in  8  byte read from BRAM during UNLOAD.
- `host_instruction`  out  8  instruction to the controller; 8'h00 (NOP) when not issuing.
- `host_data`  out  8  LOAD byte to the controller.
- `done`  out  1  one-cycle pulse when a command completes.
- `err`  out  1  sticky timeout flag; cleared only by reset.

## Operation
- Op classes come from `cmd_instr[3:0]`:
  - LOAD = 0100.
  - UNLOAD = 0110.
  - NOP = `op[3:2]==00`.
  - All other encodings are single-cycle ops (COPY, CLEAR, ADD, SHIFT, SUB, MULT).
- Internal storage: 64x8 buffer with a 6-bit index and a 7-bit byte counter.
- States and transitions:
  - `S_IDLE`: `cmd_ready=1`. On `cmd_valid`, latch `cmd_instr` and branch:
    - NOP → pulse `done`, stay in `S_IDLE`.
    - LOAD → `S_FILL`.
    - Any other op → `S_WAIT`.
  - `S_FILL`: `in_ready=1`. Each `in_valid` writes `buf[idx]`. After byte 63 → `S_WAIT`.
  - `S_WAIT`: wait until `busy==0`, then → `S_ISSUE`. The timeout counter runs here.
  - `S_ISSUE`: one cycle with `host_instruction` = latched instruction. Then go to `S_STREAM` (LOAD), `S_CAPTURE` (UNLOAD) or `S_DONE` (others).
  - `S_STREAM`: 64 cycles; `host_data=buf[k]` in cycle k. Then → `S_DONE`.
  - `S_CAPTURE`: `CAP_DELAY` idle cycles, then 64 cycles writing `unload_data` to `buf[k]`. Then → `S_DRAIN`.
  - `S_DRAIN`: `out_valid=1`, `out_data=buf[idx]`. `idx` advances on `out_ready`. After byte 63 → `S_DONE`.
  - `S_DONE`: wait for `busy==0`, pulse `done`, → `S_IDLE`.
- `host_instruction` is 8'h00 in every state except `S_ISSUE`. This prevents the controller re-decoding the instruction on its return to IDLE.
- Timeout: if `busy` stays high for `TIMEOUT` consecutive cycles in `S_WAIT` or `S_DONE`:
  - set `err`;
  - pulse `done`;
  - return to `S_IDLE`.
- Index arithmetic: the 6-bit index wraps 63→0, and that wrap marks chunk end. The byte counter never exceeds 64.

## Timing
- Reset values (asynchronous on `reset_n` low, held until the first edge after release):
  - state = `S_IDLE`;
  - `cmd_ready=1`;
  - `host_instruction=8'h00`, `host_data=8'h00`;
  - `in_ready=0`, `out_valid=0`, `out_data=8'h00`;
  - `done=0`, `err=0`;
  - counters = 0.
- Buffer contents are undefined after reset.
- Issue cycle T: the controller samples the instruction at the rising edge ending T.
- LOAD streaming: byte k is stable on `host_data` throughout cycle T+1+k, for k=0..63.
- UNLOAD capture: byte k is sampled at the edge ending cycle T+1+CAP_DELAY+k.
- Single-cycle op latency from `cmd_valid` acceptance (controller idle): issue at +2 cycles, `done` at +4 or later.
- LOAD latency: 64 fill cycles (with `in_valid` held high), then wait, issue, 64 stream cycles, then `done` once `busy` is low.
- `cmd_ready` is high only in `S_IDLE`; a command offered in any other state is not accepted.
- Reset asserted mid-operation: abort immediately; no partial `done`; `host_instruction` returns to 8'h00.
- `in_valid`/`out_ready` stalls in FILL/DRAIN are unbounded. STREAM and CAPTURE never stall.

## Test plan
- Reset mid-STREAM: assert `reset_n` low at byte 30 → all outputs at reset values within the same cycle; `done` never pulses.
- ADD (8'h6C) with `busy=0` → `host_instruction=8'h6C` for exactly one cycle, then 8'h00; `done` one cycle after `busy` is seen low.
- LOAD 8'h04 with fill bytes 0x00..0x3F → after issue cycle T, `host_data` equals k in cycle T+1+k for k=0..63.
- UNLOAD 8'h86, `CAP_DELAY=1`, controller model returning 0xA0+k → `out_data` sequence 0xA0..0xDF; `out_ready` toggled 50% still delivers all 64 bytes in order.
- `busy` held high during `S_WAIT` → `err=1` at `TIMEOUT` cycles, `done` pulses, `cmd_ready` returns to 1, and `err` stays set.
- NOP 8'hF3 → `done` pulse and `host_instruction` stays 8'h00; a second `cmd_valid` during LOAD fill is not accepted.

Source files
------------

// File: rtl/mpu_host_sequencer_if.sv
// Host-facing streams of the MPU host sequencer:
// command port, LOAD fill stream and UNLOAD drain stream.
interface mpu_host_sequencer_if;
    logic       cmd_valid;
    logic [7:0] cmd_instr;
    logic       cmd_ready;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport master (
        output cmd_valid, cmd_instr,
        input  cmd_ready,
        output in_valid, in_data,
        input  in_ready,
        input  out_valid, out_data,
        output out_ready
    );

    modport slave (
        input  cmd_valid, cmd_instr,
        output cmd_ready,
        input  in_valid, in_data,
        output in_ready,
        output out_valid, out_data,
        input  out_ready
    );
endinterface

// File: rtl/mpu_host_sequencer.sv
// Host-side issuer for the MPU instruction controller: one-cycle issue,
// LOAD chunk pre-buffer/stream and UNLOAD capture/drain.
module mpu_host_sequencer #(
    parameter int CHUNK_BYTES = 64,
    parameter int CAP_DELAY   = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mpu_host_sequencer_if.slave  host,
    input  logic                 busy,
    input  logic [7:0]           unload_data,
    output logic [7:0]           host_instruction,
    output logic [7:0]           host_data,
    output logic                 done,
    output logic                 err
);
    localparam int IW = $clog2(CHUNK_BYTES);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_WAIT, S_ISSUE,
        S_STREAM, S_CAPTURE, S_DRAIN, S_DONE
    } state_t;

    state_t          state, nxt;
    logic [7:0]      instr;
    logic [IW-1:0]   idx;
    logic [6:0]      cnt;
    logic [TW-1:0]   tmo;
    logic            done_q, err_q;
    logic [7:0]      mem [CHUNK_BYTES];

    logic cmd_nop, cmd_load, op_load, op_unload;
    logic last, cap_go, waiting, tmo_hit;

    assign cmd_nop   = host.cmd_instr[3:2] == 2'b00;
    assign cmd_load  = host.cmd_instr[3:0] == 4'b0100;
    assign op_load   = instr[3:0] == 4'b0100;
    assign op_unload = instr[3:0] == 4'b0110;
    assign last      = idx == IW'(CHUNK_BYTES - 1);
    assign cap_go    = cnt == 7'(CAP_DELAY);
    assign waiting   = (state == S_WAIT) || (state == S_DONE);
    // Fires on the TIMEOUT-th consecutive busy cycle.
    assign tmo_hit   = waiting && busy && (tmo == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:
                if (host.cmd_valid && !cmd_nop)
                    nxt = cmd_load ? S_FILL : S_WAIT;
            S_FILL:
                if (host.in_valid && last) nxt = S_WAIT;
            S_WAIT:
                if (!busy)        nxt = S_ISSUE;
                else if (tmo_hit) nxt = S_IDLE;
            S_ISSUE:
                nxt = op_load   ? S_STREAM  :
                      op_unload ? S_CAPTURE : S_DONE;
            S_STREAM:
                if (last) nxt = S_DONE;
            S_CAPTURE:
                if (cap_go && last) nxt = S_DRAIN;
            S_DRAIN:
                if (host.out_ready && last) nxt = S_DONE;
            S_DONE:
                if (!busy || tmo_hit) nxt = S_IDLE;
            default:
                nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr  <= 8'h00;
            idx    <= '0;
            cnt    <= '0;
            tmo    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (state == S_IDLE && host.cmd_valid) instr <= host.cmd_instr;

            // Every chunk phase ends on the index wrap, so idx is 0 on entry.
            if ((state == S_FILL && host.in_valid) ||
                (state == S_STREAM) ||
                (state == S_CAPTURE && cap_go) ||
                (state == S_DRAIN && host.out_ready))
                idx <= idx + IW'(1);

            if (state == S_CAPTURE) begin
                if (!cap_go) cnt <= cnt + 7'd1;
            end else begin
                cnt <= '0;
            end

            if (waiting && busy) tmo <= tmo_hit ? '0 : tmo + TW'(1);
            else                 tmo <= '0;

            done_q <= (state == S_IDLE && host.cmd_valid && cmd_nop) ||
                      (state == S_DONE && !busy) || tmo_hit;
            err_q  <= err_q | tmo_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_FILL && host.in_valid)
            mem[idx] <= host.in_data;
        else if (state == S_CAPTURE && cap_go)
            mem[idx] <= unload_data;
    end

    always_comb begin
        host.cmd_ready   = state == S_IDLE;
        host.in_ready    = state == S_FILL;
        host.out_valid   = state == S_DRAIN;
        host.out_data    = (state == S_DRAIN) ? mem[idx] : 8'h00;
        host_instruction = (state == S_ISSUE) ? instr : 8'h00;
        host_data        = (state == S_STREAM) ? mem[idx] : 8'h00;
        done             = done_q;
        err              = err_q;
    end
endmodule
